sobel_result_packer: RTL
========================

# sobel_result_packer

Output-side writer for the Sobel convolution path. Accepts one filtered 8-bit result pixel per handshake from the convolution core and packs four pixels into 32-bit words. Emits the words in order, with a sequential word address, over a valid/ready interface to the result capture/storage stage. Raises `conv_fin` once the last word of the frame has been accepted downstream.

## Interface
- `PIX_W`, 8, result pixel width
- `PIX_PER_WORD`, 4, pixels per output word (output width = `PIX_W*PIX_PER_WORD` = 32)
- `IMG_W`, 64, frame width in result pixels
- `IMG_H`, 64, frame height in result pixels
- `ADDR_W`, 10, word address width; must hold `ceil(IMG_W*IMG_H/PIX_PER_WORD)-1`

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  frame enable; level-sensitive
- `pix_valid`  in  1  result pixel present
- `pix_data`  in  8  result pixel
- `pix_ready`  out  1  packer accepts `pix_data` this cycle
- `word_valid`  out  1  `word_data`/`word_addr` valid
- `word_data`  out  32  packed word
- `word_addr`  out  10  word index within frame, 0-based
- `word_ready`  in  1  downstream accepts the word
- `conv_fin`  out  1  frame complete; level
- `busy`  out  1  high in RUN or DRAIN

## Operation
- Pixel transfer: `pix_valid && pix_ready` at a rising edge. Word transfer: `word_valid && word_ready` at a rising edge.
- Packing is little-endian. The first pixel of a word goes to `[7:0]`, the second to `[15:8]`, the third to `[23:16]`, the fourth to `[31:24]`.
- A lane counter (0..3) selects the byte position. The counter wraps to 0 when a word completes.
- Completed words enter a 2-entry output FIFO. `word_data`/`word_addr` are driven from the FIFO head.
- The word address counter starts at 0 and increments per word pushed into the FIFO. It never wraps within a frame.
- FSM states:
  - IDLE → RUN when `en`=1. On entry: clear pixel count, lane, and address.
  - RUN: accept pixels. After the pixel with count `IMG_W*IMG_H-1` is accepted → DRAIN.
  - DRAIN: push the final word. Unused upper lanes are zero-padded if the frame is not a multiple of 4. Wait for the FIFO to empty → DONE.
  - DONE: `conv_fin`=1. Stay until `en`=0 → IDLE.
- `pix_ready` = (state==RUN) && `en` && !(lane==3 && FIFO full).
  - Lanes 0–2 are accepted even when the FIFO is full.
- `en`=0 in RUN pauses input: `pix_ready`=0, and lane, count, and state are held. The FIFO keeps draining.
- `en`=0 in DRAIN has no effect; the frame completes.
- FIFO full with a 4th pixel pending: `pix_ready`=0 until a word transfer frees an entry. A word popped in the same cycle counts as free space for that cycle's push.
- `pix_data` is ignored while `pix_valid`=0 or `pix_ready`=0.

## Timing
- Reset values: `pix_ready`=0, `word_valid`=0, `word_data`=0, `word_addr`=0, `conv_fin`=0, `busy`=0. State IDLE, lane 0, FIFO empty.
- `rst_n` assertion mid-frame immediately discards the partial word and the FIFO contents and returns to IDLE. No `conv_fin` is raised.
- Latency: when the 4th pixel is accepted at edge N with the FIFO empty, `word_valid`=1 with that word after edge N.
- `pix_ready` may rise in the cycle after IDLE→RUN, i.e. the second edge with `en`=1.
- `word_valid`, `word_data`, and `word_addr` are stable while `word_valid`=1 and `word_ready`=0.
- Throughput: 1 pixel/cycle sustained while `word_ready`=1.
- `conv_fin` rises in the cycle after the last word transfer. It falls in the cycle after `en` is sampled low.
- All outputs are registered or derived from registered state only. There is no combinational path from `word_ready` to `pix_ready` beyond the FIFO-full term.

## Structure
- Shared package `sobel_pkg`: FSM state encoding (IDLE, RUN, DRAIN, DONE), and `PIX_W`, `PIX_PER_WORD`, `IMG_W`, `IMG_H` defaults shared with the convolution core.
- One sub-module, `sync_fifo2`: a 2-entry, 42-bit (data+addr) synchronous FIFO with push/pop/full/empty.
- Packing register, lane/pixel/address counters, and the FSM live in the top.

## Test plan
- Stream pixels 0x01..0x08 with `word_ready`=1 → words 0x04030201 @ addr 0 and 0x08070605 @ addr 1, each one cycle after the 4th pixel.
- Full 64×64 frame, pixel = index[7:0], `word_ready`=1 → 1024 words, addr 0..1023, last word 0xFFFEFDFC. `conv_fin`=1 the cycle after word 1023 transfers, and stays high until `en`=0.
- Hold `word_ready`=0 while streaming → 2 words buffered, then `pix_ready` drops at lane 3 of the third word. Release `word_ready` → no loss or duplication, addresses continuous.
- Frame 3×3 (`IMG_W`=`IMG_H`=3, 9 pixels 0xA1..0xA9) → 3 words, last word = 0x000000A9.
- Drop `en` for 5 cycles mid-word (lane 2) → `pix_ready`=0 during the gap, and the word resumes intact when `en` returns.
- Assert `rst_n`=0 after 10 pixels → all outputs return to reset values. A new frame then starts at addr 0 with lane 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel convolution path: frame geometry defaults
// and the result packer FSM encoding.
package sobel_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned IMG_W        = 64;
  localparam int unsigned IMG_H        = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } packer_state_e;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO. A pop in the same cycle frees space for a push,
// so a full FIFO can accept a word while its head is being taken.
module sync_fifo2 #(
  parameter int unsigned Width = 42
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0][Width-1:0] mem_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sobel_result_packer.sv
// Packs filtered Sobel result pixels little-endian into words and streams them,
// with a running word address, to the result storage stage.
module sobel_result_packer #(
  parameter int unsigned PIX_W        = sobel_pkg::PIX_W,
  parameter int unsigned PIX_PER_WORD = sobel_pkg::PIX_PER_WORD,
  parameter int unsigned IMG_W        = sobel_pkg::IMG_W,
  parameter int unsigned IMG_H        = sobel_pkg::IMG_H,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          pix_valid_i,
  input  logic [PIX_W-1:0]              pix_data_i,
  output logic                          pix_ready_o,
  output logic                          word_valid_o,
  output logic [PIX_W*PIX_PER_WORD-1:0] word_data_o,
  output logic [ADDR_W-1:0]             word_addr_o,
  input  logic                          word_ready_i,
  output logic                          conv_fin_o,
  output logic                          busy_o
);

  import sobel_pkg::*;

  localparam int unsigned WordW = PIX_W * PIX_PER_WORD;
  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned CntW  = $clog2(NPix + 1);
  localparam int unsigned LaneW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [LaneW-1:0] LaneLast = LaneW'(PIX_PER_WORD - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(NPix - 1);

  packer_state_e state_q, state_d;
  logic [LaneW-1:0]                    lane_q, lane_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [PIX_PER_WORD-1:0][PIX_W-1:0]  pack_q, pack_d;
  logic [PIX_PER_WORD-1:0][PIX_W-1:0]  pix_word;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ADDR_W+WordW-1:0] fifo_wdata;
  logic [ADDR_W+WordW-1:0] fifo_rdata;
  logic                    pix_fire;

  sync_fifo2 #(
    .Width(ADDR_W + WordW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(fifo_wdata),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign word_valid_o = !fifo_empty;
  assign word_data_o  = fifo_rdata[WordW-1:0];
  assign word_addr_o  = fifo_rdata[WordW +: ADDR_W];
  assign fifo_pop     = word_valid_o && word_ready_i;

  // Only the word-completing lane needs FIFO space; earlier lanes just fill the pack register.
  assign pix_ready_o = (state_q == StRun) && en_i && !((lane_q == LaneLast) && fifo_full);
  assign pix_fire    = pix_valid_i && pix_ready_o;

  assign conv_fin_o = (state_q == StDone);
  assign busy_o     = (state_q == StRun) || (state_q == StDrain);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    pack_d     = pack_q;
    fifo_push  = 1'b0;
    fifo_wdata = {addr_q, pack_q};
    pix_word   = pack_q;
    pix_word[lane_q] = pix_data_i;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StRun;
          lane_d  = '0;
          cnt_d   = '0;
          addr_d  = '0;
          pack_d  = '0;
        end
      end
      StRun: begin
        if (pix_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (lane_q == LaneLast) begin
            fifo_push  = 1'b1;
            fifo_wdata = {addr_q, pix_word};
            addr_d     = addr_q + 1'b1;
            lane_d     = '0;
            pack_d     = '0;
          end else begin
            pack_d = pix_word;
            lane_d = lane_q + 1'b1;
          end
          if (cnt_q == CntLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (lane_q != '0) begin
          // Partial final word; unused lanes are still zero from the last clear.
          if (!fifo_full || fifo_pop) begin
            fifo_push  = 1'b1;
            fifo_wdata = {addr_q, pack_q};
            addr_d     = addr_q + 1'b1;
            lane_d     = '0;
            pack_d     = '0;
          end
        end else if (fifo_empty || (fifo_pop && !fifo_full)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!en_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pack_q  <= pack_d;
    end
  end

endmodule
